// File: rtl/banked_unified_buffer.sv
// Banked unified buffer: one row store shared by two arbitrated writers, a clear
// engine and NUM_RD_PORTS registered read ports with write-first bypass.
module banked_unified_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int LANES        = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_RD_PORTS = 3
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   wa_valid,
  output logic                                                   wa_ready,
  input  logic [ADDR_WIDTH-1:0]                                  wa_addr,
  input  logic [LANES-1:0]                                       wa_mask,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]                       wa_data,
  input  logic                                                   wb_valid,
  output logic                                                   wb_ready,
  input  logic [ADDR_WIDTH-1:0]                                  wb_addr,
  input  logic [LANES-1:0]                                       wb_mask,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]                       wb_data,
  input  logic [NUM_RD_PORTS-1:0]                                rd_en,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]                rd_addr,
  output logic [NUM_RD_PORTS-1:0][LANES-1:0][DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_RD_PORTS-1:0]                                rd_valid,
  input  logic                                                   clr_start,
  output logic                                                   clr_busy,
  output logic                                                   clr_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] row_t;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LANES-1:0]      mask;
    row_t                  data;
  } wr_req_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    last_b_q, last_b_d;
  row_t                    mem [DEPTH];
  wr_req_t                 wr;
  row_t [NUM_RD_PORTS-1:0] byp_row;
  row_t [NUM_RD_PORTS-1:0] rd_data_q;
  logic [NUM_RD_PORTS-1:0] rd_valid_q;

  assign clr_busy = (state_q != S_IDLE);
  assign clr_done = (state_q == S_DONE);

  // Tie goes to whichever writer did not win last; the clear engine owns the array while busy.
  assign wa_ready = ~clr_busy & wa_valid & (~wb_valid | last_b_q);
  assign wb_ready = ~clr_busy & wb_valid & (~wa_valid | ~last_b_q);

  always_comb begin
    wr       = '0;
    last_b_d = last_b_q;
    if (state_q == S_CLEAR) begin
      wr.en   = 1'b1;
      wr.addr = cnt_q;
      wr.mask = '1;
    end else if (wa_valid && wa_ready) begin
      wr       = '{en: 1'b1, addr: wa_addr, mask: wa_mask, data: wa_data};
      last_b_d = 1'b0;
    end else if (wb_valid && wb_ready) begin
      wr       = '{en: 1'b1, addr: wb_addr, mask: wb_mask, data: wb_data};
      last_b_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (clr_start) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  // Row storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr.en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr.mask[l]) mem[wr.addr][l] <= wr.data[l];
      end
    end
  end

  // Same-cycle write to the read row is merged lane-by-lane (write-first).
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      byp_row[p] = mem[rd_addr[p]];
      if (wr.en && (wr.addr == rd_addr[p])) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr.mask[l]) byp_row[p][l] = wr.data[l];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_valid_q <= rd_en;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_en[p]) rd_data_q[p] <= byp_row[p];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: doc/banked_unified_buffer.md
# banked_unified_buffer

Next-generation on-chip unified buffer. It provides SRAM row storage of LANES × DATA_WIDTH bits with a parametrised number of synchronous read ports. It has two write ports with valid/ready handshakes, an internal round-robin arbiter, per-lane write masks and write-first read bypass. A hardware clear engine zeroes the whole array. It sits between the AXI slave (writer A), the VPU (writer B) and the systolic array, skew buffer and VPU read clients, and it removes the external write arbiter from tpu_top.

## Interface
Parameters:
- DATA_WIDTH, 32: bits per lane.
- LANES, 16: lanes per row; row width is LANES*DATA_WIDTH.
- ADDR_WIDTH, 10: row address bits; DEPTH = 2**ADDR_WIDTH.
- NUM_RD_PORTS, 3: independent read ports, minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- wa_valid  in  1  writer A (host) request.
- wa_ready  out  1  writer A granted; the write commits on the edge where valid&&ready.
- wa_addr  in  ADDR_WIDTH  writer A row address.
- wa_mask  in  LANES  writer A per-lane write enable.
- wa_data  in  [LANES] × DATA_WIDTH  writer A data; lane 0 is the least-significant lane.
- wb_valid, wb_ready, wb_addr, wb_mask, wb_data: writer B (VPU), identical to writer A.
- rd_en  in  [NUM_RD_PORTS] × 1  per-port read enable.
- rd_addr  in  [NUM_RD_PORTS] × ADDR_WIDTH  per-port read address.
- rd_data  out  [NUM_RD_PORTS][LANES] × DATA_WIDTH  per-port registered read data.
- rd_valid  out  [NUM_RD_PORTS] × 1  high for exactly the cycle after rd_en.
- clr_start  in  1  clear request; sampled only in IDLE.
- clr_busy  out  1  high in CLEAR and DONE.
- clr_done  out  1  one-cycle pulse in DONE.

## Operation
- Storage: DEPTH rows. Each lane is independently write-enabled.
- Storage is not reset. Its contents are undefined until written or cleared.
- Write arbitration:
  - Only A valid: A is granted. Only B valid: B is granted.
  - Both valid: round-robin; the writer not granted last time wins.
  - The last-grant pointer updates only on a committed write. After reset it points to B, so A wins the first tie.
- wa_ready and wb_ready are combinational from the valids and the pointer. At most one is high per cycle.
- Both readys are forced low while clr_busy is high.
- Masked write: lanes with mask=1 take the new data; lanes with mask=0 keep their old value. A mask of all zeros still counts as a handshake and still advances the pointer.
- Read: when rd_en[p]=1, rd_data[p] registers the row at rd_addr[p] and rd_valid[p] goes high on the next cycle. When rd_en[p]=0, rd_data[p] holds its value.
- Write-first bypass: if a committed write in cycle N has the same address as rd_addr[p] with rd_en[p]=1:
  - rd_data[p] returns the new data on masked lanes and the old data on unmasked lanes.
  - This applies to every port at once and also to clear-engine writes.
- Reads are permitted during a clear.
- Clear FSM:
  - IDLE → CLEAR on clr_start, with counter = 0.
  - CLEAR: write all-zero to row `counter` with a full mask, then counter++. After row DEPTH-1 → DONE.
  - DONE: pulse clr_done for one cycle → IDLE.
  - clr_start is ignored outside IDLE.
- Address arithmetic: all addresses are plain ADDR_WIDTH unsigned values. The counter wraps only by leaving CLEAR.

## Timing
- Reset values:
  - rd_data all 0, rd_valid 0.
  - FSM IDLE, counter 0, clr_busy 0, clr_done 0.
  - Pointer = B.
  - wa_ready/wb_ready follow their valids with A priority.
- Write latency: the row is updated at the commit edge and is readable (with bypass) in that same cycle's read.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data.
- Clear duration: clr_busy is high for DEPTH+1 cycles (DEPTH in CLEAR, 1 in DONE), starting the cycle after clr_start.
- Reset mid-clear: everything returns to reset values immediately. Partially cleared rows are undefined.
- Reset mid-read: rd_valid drops at once and rd_data is zeroed.
- Holding valid with ready low: the writer must keep address, mask and data stable. The buffer never drops a request.

## Test plan
- Write A to addr 5, mask 0xFFFF, lane i = i+1; next cycle rd_en[0] at addr 5 → one cycle later rd_valid[0]=1 and lane i = i+1.
- Write 0xFFFFFFFF to all lanes of addr 3, then write 0xA5 with mask 0x00FF; read → lanes 0-7 = 0xA5, lanes 8-15 = 0xFFFFFFFF.
- wa_valid and wb_valid held high for 6 cycles at distinct addresses → grants A,B,A,B,A,B; both readys are never high together; all six rows read back correctly.
- In one cycle, commit B to addr 9 (data 0x1234 in all lanes) while every port has rd_en=1 at addr 9 → all ports return 0x1234 on the next cycle.
- Pulse clr_start → clr_busy high for 1025 cycles, both readys low throughout, clr_done pulses once; a second clr_start at cycle 10 has no effect; reading rows 0, 512 and 1023 afterwards gives all zeros.
- Assert rst at cycle 100 of a clear → clr_busy=0, rd_valid=0, rd_data=0 immediately; a new clr_start after reset completes normally.
